// File: rtl/cache_pkg.sv
// Shared definitions for the cache miss controller: geometry constants,
// FSM state encoding, byte-address field layout and the helper that builds
// word-aligned memory addresses.
package cache_pkg;

    localparam int CACHE_ADDR_W  = 32;
    localparam int CACHE_E       = 4;    // ways per set
    localparam int CACHE_S       = 16;   // sets
    localparam int CACHE_B       = 4;    // 32-bit words per line
    localparam int CACHE_SEL_W   = $clog2(CACHE_E);
    localparam int CACHE_WORD_W  = $clog2(CACHE_B);
    localparam int CACHE_INDEX_W = $clog2(CACHE_S);
    localparam int CACHE_TAG_W   = CACHE_ADDR_W - CACHE_INDEX_W - CACHE_WORD_W - 2;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOOKUP     = 3'd1,
        EVICT      = 3'd2,
        WRITE_BACK = 3'd3,
        REFILL     = 3'd4,
        UPDATE     = 3'd5
    } state_e;

    typedef struct packed {
        logic [CACHE_TAG_W-1:0]   tag;
        logic [CACHE_INDEX_W-1:0] index;
        logic [CACHE_WORD_W-1:0]  word;
        logic [1:0]               byte_off;
    } addr_t;

    function automatic logic [CACHE_ADDR_W-1:0] make_mem_addr(
        input logic [CACHE_TAG_W-1:0]   tag,
        input logic [CACHE_INDEX_W-1:0] index,
        input logic [CACHE_WORD_W-1:0]  word
    );
        return {tag, index, word, 2'b00};
    endfunction

endpackage

// File: rtl/cache_miss_controller.sv
// Per-request control FSM for the set-associative cache. One CPU access is
// handled at a time: hits complete in the lookup cycle, misses pick a victim
// through replace_controller, write it back if dirty, refill it word by word
// and replay the lookup.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-low reset
//   req_*_i / req_ready_o    CPU request handshake, resp_valid_o completion pulse
//   hit_i, hit_line_i        tag compare result for the latched set
//   victim_dirty_i/tag_i     state of the way selected by line_sel_o
//   strategy_en_o, repl_write_en_o, line_write_o, line_replace_i
//                            replace_controller interface
//   index_o, line_sel_o, word_sel_o, data_write_en_o, data_src_mem_o,
//   tag_write_en_o, set_dirty_o
//                            cache array controls
//   mem_req_o, mem_write_o, mem_addr_o, mem_ack_i
//                            word-wide memory handshake
//
// Geometry parameters must match the cache_pkg constants, since the address
// struct and address helper are sized from the package.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | ready for a CPU request
// LOOKUP     | tag compare; hit completes, miss requests a victim way
// EVICT      | sample victim dirty bit and tag, clear word counter
// WRITE_BACK | write dirty victim line to memory word by word
// REFILL     | read requested line from memory into victim way
// UPDATE     | write tag/valid, record access, then replay LOOKUP
module cache_miss_controller
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = CACHE_ADDR_W,
    parameter int SET_SIZE    = CACHE_E,
    parameter int SET_NUM     = CACHE_S,
    parameter int LINE_WORDS  = CACHE_B,
    parameter int SEL_WIDTH   = $clog2(SET_SIZE),
    parameter int WORD_WIDTH  = $clog2(LINE_WORDS),
    parameter int INDEX_WIDTH = $clog2(SET_NUM),
    parameter int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - WORD_WIDTH - 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    input  logic                   req_write_i,
    input  logic [ADDR_WIDTH-1:0]  req_addr_i,
    output logic                   req_ready_o,
    output logic                   resp_valid_o,
    input  logic                   hit_i,
    input  logic [SEL_WIDTH-1:0]   hit_line_i,
    input  logic                   victim_dirty_i,
    input  logic [TAG_WIDTH-1:0]   victim_tag_i,
    output logic                   strategy_en_o,
    output logic                   repl_write_en_o,
    output logic [SEL_WIDTH-1:0]   line_write_o,
    input  logic [SEL_WIDTH-1:0]   line_replace_i,
    output logic [INDEX_WIDTH-1:0] index_o,
    output logic [SEL_WIDTH-1:0]   line_sel_o,
    output logic [WORD_WIDTH-1:0]  word_sel_o,
    output logic                   data_write_en_o,
    output logic                   data_src_mem_o,
    output logic                   tag_write_en_o,
    output logic                   set_dirty_o,
    output logic                   mem_req_o,
    output logic                   mem_write_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    input  logic                   mem_ack_i
);

    state_e                 state_q, state_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [INDEX_WIDTH-1:0] index_q, index_d;
    logic [WORD_WIDTH-1:0]  word_q, word_d;
    logic                   write_q, write_d;
    logic [SEL_WIDTH-1:0]   victim_q, victim_d;
    logic [TAG_WIDTH-1:0]   victim_tag_q, victim_tag_d;
    logic [WORD_WIDTH-1:0]  cnt_q, cnt_d;

    addr_t req_fields;
    logic  last_word;
    logic  unused_byte_off;

    assign req_fields      = addr_t'(req_addr_i);
    assign unused_byte_off = ^req_fields.byte_off;
    assign last_word       = (cnt_q == WORD_WIDTH'(LINE_WORDS - 1));
    assign index_o         = index_q;

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        index_d      = index_q;
        word_d       = word_q;
        write_d      = write_q;
        victim_d     = victim_q;
        victim_tag_d = victim_tag_q;
        cnt_d        = cnt_q;

        req_ready_o     = (state_q == IDLE);
        resp_valid_o    = 1'b0;
        strategy_en_o   = 1'b0;
        repl_write_en_o = 1'b0;
        line_write_o    = '0;
        line_sel_o      = '0;
        word_sel_o      = '0;
        data_write_en_o = 1'b0;
        data_src_mem_o  = 1'b0;
        tag_write_en_o  = 1'b0;
        set_dirty_o     = 1'b0;
        mem_req_o       = 1'b0;
        mem_write_o     = 1'b0;
        mem_addr_o      = '0;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    tag_d   = req_fields.tag;
                    index_d = req_fields.index;
                    word_d  = req_fields.word;
                    write_d = req_write_i;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit_i) begin
                    resp_valid_o    = 1'b1;
                    repl_write_en_o = 1'b1;
                    line_write_o    = hit_line_i;
                    if (write_q) begin
                        data_write_en_o = 1'b1;
                        line_sel_o      = hit_line_i;
                        word_sel_o      = word_q;
                        set_dirty_o     = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    strategy_en_o = 1'b1;
                    victim_d      = line_replace_i;
                    state_d       = EVICT;
                end
            end
            EVICT: begin
                line_sel_o   = victim_q;
                victim_tag_d = victim_tag_i;
                cnt_d        = '0;
                state_d      = victim_dirty_i ? WRITE_BACK : REFILL;
            end
            WRITE_BACK: begin
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                mem_addr_o  = make_mem_addr(victim_tag_q, index_q, cnt_q);
                line_sel_o  = victim_q;
                word_sel_o  = cnt_q;
                if (mem_ack_i) begin
                    if (last_word) begin
                        cnt_d   = '0;
                        state_d = REFILL;
                    end else begin
                        cnt_d = cnt_q + WORD_WIDTH'(1);
                    end
                end
            end
            REFILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = make_mem_addr(tag_q, index_q, cnt_q);
                line_sel_o = victim_q;
                word_sel_o = cnt_q;
                if (mem_ack_i) begin
                    data_write_en_o = 1'b1;
                    data_src_mem_o  = 1'b1;
                    if (last_word) begin
                        cnt_d   = '0;
                        state_d = UPDATE;
                    end else begin
                        cnt_d = cnt_q + WORD_WIDTH'(1);
                    end
                end
            end
            UPDATE: begin
                tag_write_en_o  = 1'b1;
                line_sel_o      = victim_q;
                repl_write_en_o = 1'b1;
                line_write_o    = victim_q;
                state_d         = LOOKUP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            tag_q        <= '0;
            index_q      <= '0;
            word_q       <= '0;
            write_q      <= 1'b0;
            victim_q     <= '0;
            victim_tag_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            index_q      <= index_d;
            word_q       <= word_d;
            write_q      <= write_d;
            victim_q     <= victim_d;
            victim_tag_q <= victim_tag_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule
